// File: rtl/uart_tx_ctrl.sv
// UART transmitter: frames a word as start/data/parity/stop on TxD, requested by a debounced button or tx_valid.
// TxD falls one edge after acceptance; tx_ready is low for the whole frame and requests arriving while busy are dropped.
module uart_tx_ctrl #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int BAUD            = 9600,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 send_btn,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 frame_done,
  output logic                 TxD
);
  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int IW       = $clog2(DATA_BITS);
  localparam int DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic          sync1, sync2, btn_deb, btn_deb_d;
  logic [DW-1:0] db_cnt;
  logic          press, req;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      btn_deb   <= 1'b0;
      btn_deb_d <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync1     <= send_btn;
      sync2     <= sync1;
      btn_deb_d <= btn_deb;
      // Level only moves after DEBOUNCE_CYCLES consecutive samples disagreeing with it.
      if (sync2 == btn_deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_deb <= sync2;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = btn_deb & ~btn_deb_d;
  assign req   = press | tx_valid;

  state_t                state;
  logic [CW-1:0]         baud_cnt;
  logic [IW-1:0]         bit_idx;
  logic                  stop_idx;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par_bit;
  logic                  baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      TxD        <= 1'b1;
      tx_ready   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state != S_IDLE) baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
      case (state)
        S_IDLE: if (req) begin
          state    <= S_START;
          shreg    <= data;
          par_bit  <= (PARITY == 1) ? ~^data : ^data;
          TxD      <= 1'b0;
          tx_ready <= 1'b0;
        end
        S_START: if (baud_end) begin
          state <= S_DATA;
          TxD   <= shreg[0];
        end
        S_DATA: if (baud_end) begin
          shreg   <= shreg >> 1;
          bit_idx <= (bit_idx == BIT_LAST) ? '0 : bit_idx + 1'b1;
          if (bit_idx != BIT_LAST) begin
            TxD <= shreg[1];
          end else if (PARITY != 0) begin
            state <= S_PARITY;
            TxD   <= par_bit;
          end else begin
            state <= S_STOP;
            TxD   <= 1'b1;
          end
        end
        S_PARITY: if (baud_end) begin
          state <= S_STOP;
          TxD   <= 1'b1;
        end
        S_STOP: if (baud_end) begin
          if (stop_idx == STOP_LAST) begin
            state      <= S_IDLE;
            stop_idx   <= 1'b0;
            tx_ready   <= 1'b1;
            frame_done <= 1'b1;
          end else begin
            stop_idx <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
